// File: rtl/ip2_test3_sweep_ctrl_pkg.sv
// Shared types for the IP2 test3 phase-sweep sequencer.
package cms_pix28_package;

  typedef enum logic [2:0] {
    IDLE_IP2_T3S,
    LAUNCH_IP2_T3S,
    WAIT_DONE_IP2_T3S,
    STORE_IP2_T3S,
    ADVANCE_IP2_T3S,
    FINISH_IP2_T3S
  } state_t_sm_ip2_test3_sweep;

  localparam int unsigned IP2_T3S_DNN_W   = 48;
  localparam int unsigned IP2_T3S_PHASE_W = 6;
  localparam int unsigned IP2_T3S_ITER_W  = 8;
  localparam int unsigned IP2_T3S_ENTRY_W = 110;

  // One captured test3 run as stored in the result FIFO.
  typedef struct packed {
    logic [IP2_T3S_DNN_W-1:0]   dnn_0;
    logic [IP2_T3S_DNN_W-1:0]   dnn_1;
    logic [IP2_T3S_PHASE_W-1:0] phase;
    logic [IP2_T3S_ITER_W-1:0]  iter;
  } ip2_t3s_entry_t;

endpackage

// File: rtl/ip2_sweep_fifo.sv
// First-word fall-through result FIFO; push ignored when full, pop ignored when empty.
module ip2_sweep_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head is masked so the read bus is all-zero while nothing is stored.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ip2_test3_sweep_ctrl.sv
// Sweeps the test3 trigger-out phase, launching one acquisition per step and
// queueing every captured dnn_output pair for readout.
module ip2_test3_sweep_ctrl
  import cms_pix28_package::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sweep_start,
  input  logic        sweep_abort,
  input  logic [5:0]  cfg_phase_start,
  input  logic [5:0]  cfg_phase_stop,
  input  logic [5:0]  cfg_phase_step,
  input  logic [7:0]  cfg_repeat,
  input  logic        test3_status_done,
  input  logic [47:0] test3_dnn_output_0,
  input  logic [47:0] test3_dnn_output_1,
  output logic        o_test_start_re,
  output logic [5:0]  o_test_trig_out_phase,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [47:0] rd_dnn_0,
  output logic [47:0] rd_dnn_1,
  output logic [5:0]  rd_phase,
  output logic [7:0]  rd_iter,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout_err,
  output logic        o_cfg_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t_sm_ip2_test3_sweep state, state_d;

  logic              srst;
  logic [5:0]        phase, phase_d;
  logic [7:0]        iter, iter_d;
  logic [5:0]        cfg_stop, cfg_stop_d;
  logic [5:0]        cfg_step, cfg_step_d;
  logic [7:0]        cfg_rep, cfg_rep_d;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_d;
  logic              done_prev;
  logic              start_re_d;
  logic              done_d;
  logic              tmo_err_d;
  logic              cfg_err_d;
  logic [6:0]        next_phase;
  logic [8:0]        iter_inc;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  ip2_t3s_entry_t    push_entry;
  ip2_t3s_entry_t    pop_entry;

  assign srst = reset || !enable;

  // Next-state and datapath update.
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    iter_d     = iter;
    cfg_stop_d = cfg_stop;
    cfg_step_d = cfg_step;
    cfg_rep_d  = cfg_rep;
    tmo_cnt_d  = tmo_cnt;
    start_re_d = 1'b0;
    done_d     = o_done;
    tmo_err_d  = o_timeout_err;
    cfg_err_d  = o_cfg_err;
    push       = 1'b0;
    iter_inc   = {1'b0, iter} + 9'd1;
    next_phase = {1'b0, phase} + {1'b0, cfg_step};

    unique case (state)
      IDLE_IP2_T3S: begin
        if (sweep_start) begin
          done_d     = 1'b0;
          tmo_err_d  = 1'b0;
          cfg_err_d  = 1'b0;
          cfg_stop_d = cfg_phase_stop;
          cfg_step_d = (cfg_phase_step == 6'd0) ? 6'd1 : cfg_phase_step;
          cfg_rep_d  = (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
          if (cfg_phase_start > cfg_phase_stop) begin
            cfg_err_d = 1'b1;
            state_d   = FINISH_IP2_T3S;
          end else begin
            phase_d = cfg_phase_start;
            iter_d  = 8'd0;
            state_d = LAUNCH_IP2_T3S;
          end
        end
      end
      LAUNCH_IP2_T3S: begin
        if (fifo_count != CNT_W'(FIFO_DEPTH)) begin
          start_re_d = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = WAIT_DONE_IP2_T3S;
        end
      end
      WAIT_DONE_IP2_T3S: begin
        if (test3_status_done && !done_prev) begin
          state_d = STORE_IP2_T3S;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = FINISH_IP2_T3S;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
      end
      STORE_IP2_T3S: begin
        push    = !fifo_full;
        state_d = ADVANCE_IP2_T3S;
      end
      ADVANCE_IP2_T3S: begin
        if (iter_inc < {1'b0, cfg_rep}) begin
          iter_d  = iter + 8'd1;
          state_d = LAUNCH_IP2_T3S;
        end else begin
          iter_d = 8'd0;
          if ((next_phase > {1'b0, cfg_stop}) || (next_phase > 7'd63)) begin
            state_d = FINISH_IP2_T3S;
          end else begin
            phase_d = next_phase[5:0];
            state_d = LAUNCH_IP2_T3S;
          end
        end
      end
      FINISH_IP2_T3S: begin
        done_d  = 1'b1;
        state_d = IDLE_IP2_T3S;
      end
      default: state_d = IDLE_IP2_T3S;
    endcase

    // Abort overrides any launch decided this cycle; a STORE push still lands.
    if (sweep_abort && (state inside {LAUNCH_IP2_T3S, WAIT_DONE_IP2_T3S,
                                      STORE_IP2_T3S, ADVANCE_IP2_T3S})) begin
      state_d    = FINISH_IP2_T3S;
      start_re_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state                 <= IDLE_IP2_T3S;
      phase                 <= '0;
      iter                  <= '0;
      cfg_stop              <= '0;
      cfg_step              <= '0;
      cfg_rep               <= '0;
      tmo_cnt               <= '0;
      done_prev             <= 1'b0;
      o_test_start_re       <= 1'b0;
      o_test_trig_out_phase <= '0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      o_timeout_err         <= 1'b0;
      o_cfg_err             <= 1'b0;
    end else begin
      state                 <= state_d;
      phase                 <= phase_d;
      iter                  <= iter_d;
      cfg_stop              <= cfg_stop_d;
      cfg_step              <= cfg_step_d;
      cfg_rep               <= cfg_rep_d;
      tmo_cnt               <= tmo_cnt_d;
      done_prev             <= test3_status_done;
      o_test_start_re       <= start_re_d;
      o_test_trig_out_phase <= phase_d;
      o_busy                <= (state_d != IDLE_IP2_T3S);
      o_done                <= done_d;
      o_timeout_err         <= tmo_err_d;
      o_cfg_err             <= cfg_err_d;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.dnn_0 = test3_dnn_output_0;
    push_entry.dnn_1 = test3_dnn_output_1;
    push_entry.phase = phase;
    push_entry.iter  = iter;
  end

  ip2_sweep_fifo #(
    .WIDTH (IP2_T3S_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (srst),
    .push      (push),
    .push_data (push_entry),
    .pop       (rd_ready),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_dnn_0 = pop_entry.dnn_0;
  assign rd_dnn_1 = pop_entry.dnn_1;
  assign rd_phase = pop_entry.phase;
  assign rd_iter  = pop_entry.iter;

endmodule

// File: tb/tb_ip2_test3_sweep_ctrl.sv
// Scoreboard bench for the test3 phase-sweep sequencer with a behavioural test3 model.
`timescale 1ns/1ps
module tb_ip2_test3_sweep_ctrl;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TMO      = 64;
  localparam int          DONE_DLY = 50;

  logic        clk = 1'b0;
  logic        reset, enable, sweep_start, sweep_abort;
  logic [5:0]  cfg_phase_start, cfg_phase_stop, cfg_phase_step;
  logic [7:0]  cfg_repeat;
  logic        test3_status_done = 1'b1;
  logic [47:0] test3_dnn_output_0 = '0;
  logic [47:0] test3_dnn_output_1 = '0;
  logic        o_test_start_re;
  logic [5:0]  o_test_trig_out_phase;
  logic        rd_valid, rd_ready;
  logic [47:0] rd_dnn_0, rd_dnn_1;
  logic [5:0]  rd_phase;
  logic [7:0]  rd_iter;
  logic        o_busy, o_done, o_timeout_err, o_cfg_err;

  always #5 clk = ~clk;

  ip2_test3_sweep_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .cfg_phase_start(cfg_phase_start), .cfg_phase_stop(cfg_phase_stop),
    .cfg_phase_step(cfg_phase_step), .cfg_repeat(cfg_repeat),
    .test3_status_done(test3_status_done),
    .test3_dnn_output_0(test3_dnn_output_0), .test3_dnn_output_1(test3_dnn_output_1),
    .o_test_start_re(o_test_start_re), .o_test_trig_out_phase(o_test_trig_out_phase),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_dnn_0(rd_dnn_0), .rd_dnn_1(rd_dnn_1), .rd_phase(rd_phase), .rd_iter(rd_iter),
    .o_busy(o_busy), .o_done(o_done), .o_timeout_err(o_timeout_err), .o_cfg_err(o_cfg_err)
  );

  typedef struct packed {
    logic [47:0] d0;
    logic [47:0] d1;
    logic [5:0]  ph;
    logic [7:0]  it;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   last_ph = -1;
  int   last_it = -1;

  function automatic logic [47:0] mk0(input int n);
    return 48'h5A5A_0000_0000 | 48'(n);
  endfunction

  function automatic logic [47:0] mk1(input int n);
    return 48'hC3C3_0000_0000 | 48'(n * 7 + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // test3 model: clears done on a start pulse, raises it with fresh data DONE_DLY cycles later.
  logic mdl_en  = 1'b1;
  int   run_idx = 0;
  int   mdl_cur = 0;
  int   tmr     = 0;
  int   starts  = 0;

  always @(negedge clk) begin
    if (o_test_start_re) begin
      starts++;
      test3_status_done = 1'b0;
      mdl_cur = run_idx;
      run_idx++;
      tmr = mdl_en ? DONE_DLY : 0;
    end else if (tmr > 0) begin
      tmr--;
      if (tmr == 0) begin
        test3_dnn_output_0 = mk0(mdl_cur);
        test3_dnn_output_1 = mk1(mdl_cur);
        test3_status_done  = 1'b1;
      end
    end
  end

  // Monitor: every accepted readout beat is popped against the scoreboard.
  always @(negedge clk) begin
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got phase %0d iter %0d, expected no entry", rd_phase, rd_iter);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_dnn_0", 64'(rd_dnn_0), 64'(mon_e.d0));
        chk("rd_dnn_1", 64'(rd_dnn_1), 64'(mon_e.d1));
        chk("rd_phase", 64'(rd_phase), 64'(mon_e.ph));
        chk("rd_iter",  64'(rd_iter),  64'(mon_e.it));
        last_ph = int'(rd_phase);
        last_it = int'(rd_iter);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic [5:0] s, input logic [5:0] p, input logic [5:0] st,
                       input logic [7:0] r);
    cfg_phase_start = s;
    cfg_phase_stop  = p;
    cfg_phase_step  = st;
    cfg_repeat      = r;
    sweep_start     = 1'b1;
    tick(1);
    sweep_start     = 1'b0;
    cfg_phase_start = 6'd0;
    cfg_phase_stop  = 6'd0;
    cfg_phase_step  = 6'd0;
    cfg_repeat      = 8'd0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (o_done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 64'(o_done), 64'd1);
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int n = 0;
    while (starts < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, 64'(starts), 64'(target));
  endtask

  task automatic expect_entry(input int idx, input int ph, input int it);
    exp_t e;
    e.d0 = mk0(idx);
    e.d1 = mk1(idx);
    e.ph = 6'(ph);
    e.it = 8'(it);
    sb.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int base;
    int k;
    reset = 1'b1; enable = 1'b1; sweep_start = 1'b0; sweep_abort = 1'b0;
    cfg_phase_start = '0; cfg_phase_stop = '0; cfg_phase_step = '0; cfg_repeat = '0;
    rd_ready = 1'b1;
    tick(3);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_start_re", 64'(o_test_start_re), 64'd0);
    chk("rst_phase", 64'(o_test_trig_out_phase), 64'd0);
    chk("rst_rd_dnn_0", 64'(rd_dnn_0), 64'd0);
    reset = 1'b0;
    tick(2);

    // Phases 10..12, one run each.
    s0 = starts; base = run_idx;
    for (int i = 0; i < 3; i++) expect_entry(base + i, 10 + i, 0);
    sweep(6'd10, 6'd12, 6'd1, 8'd1);
    chk("t1_busy", 64'(o_busy), 64'd1);
    wait_done("t1_done", 1000);
    chk("t1_starts", 64'(starts - s0), 64'd3);
    chk("t1_tmo_err", 64'(o_timeout_err), 64'd0);
    chk("t1_cfg_err", 64'(o_cfg_err), 64'd0);
    tick(4);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    chk("t1_valid", 64'(rd_valid), 64'd0);

    // Full sweep, step 0 -> 1, repeat 2, readout stalled at first.
    rd_ready = 1'b0;
    s0 = starts; base = run_idx;
    for (int p = 0; p < 64; p++)
      for (int i = 0; i < 2; i++) expect_entry(base + p * 2 + i, p, i);
    sweep(6'd0, 6'd63, 6'd0, 8'd2);
    wait_starts("t2_four_starts", s0 + 4, 1000);
    tick(300);
    chk("t2_stall_no_5th", 64'(starts - s0), 64'd4);
    chk("t2_stall_busy", 64'(o_busy), 64'd1);
    chk("t2_stall_valid", 64'(rd_valid), 64'd1);
    rd_ready = 1'b1;
    wait_done("t2_done", 20000);
    chk("t2_starts", 64'(starts - s0), 64'd128);
    tick(5);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    chk("t2_last_phase", 64'(last_ph), 64'd63);
    chk("t2_last_iter", 64'(last_it), 64'd1);

    // Step overshoots 63 after the first phase.
    s0 = starts; base = run_idx;
    expect_entry(base, 60, 0);
    sweep(6'd60, 6'd63, 6'd5, 8'd1);
    wait_done("t3_done", 1000);
    chk("t3_starts", 64'(starts - s0), 64'd1);
    tick(4);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // start > stop.
    s0 = starts;
    sweep(6'd20, 6'd5, 6'd1, 8'd1);
    wait_done("t4_done", 3);
    chk("t4_cfg_err", 64'(o_cfg_err), 64'd1);
    tick(20);
    chk("t4_starts", 64'(starts - s0), 64'd0);
    chk("t4_valid", 64'(rd_valid), 64'd0);

    // Model never completes -> timeout exactly TMO cycles after the start pulse.
    mdl_en = 1'b0;
    s0 = starts;
    sweep(6'd5, 6'd5, 6'd1, 8'd1);
    chk("t5_cfg_err_cleared", 64'(o_cfg_err), 64'd0);
    k = 0;
    do begin @(negedge clk); k++; end while (o_test_start_re !== 1'b1 && k < 10);
    chk("t5_start_seen", 64'(o_test_start_re), 64'd1);
    k = 0;
    do begin @(negedge clk); k++; end while (o_timeout_err !== 1'b1 && k < 200);
    chk("t5_timeout_latency", 64'(k), 64'(TMO));
    wait_done("t5_done", 5);
    chk("t5_valid", 64'(rd_valid), 64'd0);
    mdl_en = 1'b1;

    // Abort while the 2nd run is in WAIT_DONE.
    rd_ready = 1'b0;
    s0 = starts; base = run_idx;
    expect_entry(base, 30, 0);
    sweep(6'd30, 6'd35, 6'd1, 8'd1);
    chk("t6_tmo_err_cleared", 64'(o_timeout_err), 64'd0);
    wait_starts("t6_two_starts", s0 + 2, 1000);
    tick(10);
    sweep_abort = 1'b1;
    tick(1);
    sweep_abort = 1'b0;
    tick(1);
    chk("t6_busy_low", 64'(o_busy), 64'd0);
    chk("t6_done", 64'(o_done), 64'd1);
    chk("t6_valid", 64'(rd_valid), 64'd1);
    tick(100);
    chk("t6_no_relaunch", 64'(starts - s0), 64'd2);
    rd_ready = 1'b1;
    tick(3);
    chk("t6_single_entry", 64'(rd_valid), 64'd0);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    // Synchronous reset mid-sweep with entries pending.
    rd_ready = 1'b0;
    s0 = starts;
    sweep(6'd0, 6'd10, 6'd1, 8'd1);
    wait_starts("t7_three_starts", s0 + 3, 1000);
    tick(5);
    chk("t7_pre_valid", 64'(rd_valid), 64'd1);
    reset = 1'b1;
    tick(1);
    chk("t7_busy", 64'(o_busy), 64'd0);
    chk("t7_valid", 64'(rd_valid), 64'd0);
    chk("t7_done", 64'(o_done), 64'd0);
    chk("t7_phase", 64'(o_test_trig_out_phase), 64'd0);
    chk("t7_start_re", 64'(o_test_start_re), 64'd0);
    chk("t7_rd_dnn_0", 64'(rd_dnn_0), 64'd0);
    reset = 1'b0;
    rd_ready = 1'b1;
    tick(200);
    chk("t7_no_relaunch", 64'(starts - s0), 64'd3);
    chk("t7_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip2_test3_sweep_ctrl.md
Name: ip2_test3_sweep_ctrl

Overview:
Sequencer wrapped around the IP2 test3 acquisition state machine (DUT reset pulse plus trigger, capturing 48 samples of dnn_output_0/1).
- Launches repeated test3 runs while sweeping the trigger-out phase from a start to a stop value.
- Waits for each run to complete and pushes each captured pair of 48-bit words into a result FIFO, drained by the readout side over a valid/ready handshake.
- Sits between the software-facing control registers and the test3 block.

Parameters:
FIFO_DEPTH, 4, result FIFO entries; power of 2, minimum 2
TIMEOUT_CYCLES, 4096, maximum clk cycles to wait for one test3 completion

Ports:
clk  in  1  FM clock, 400 MHz (pl_clk1)
reset  in  1  synchronous, active-high
enable  in  1  block enable; low acts as reset
sweep_start  in  1  single-cycle start pulse
sweep_abort  in  1  single-cycle abort pulse
cfg_phase_start  in  6  first trigger phase
cfg_phase_stop  in  6  last trigger phase, inclusive
cfg_phase_step  in  6  phase increment; 0 is treated as 1
cfg_repeat  in  8  runs per phase; 0 is treated as 1
test3_status_done  in  1  test3 done flag (level)
test3_dnn_output_0  in  48  test3 capture word 0
test3_dnn_output_1  in  48  test3 capture word 1
o_test_start_re  out  1  start pulse to test3
o_test_trig_out_phase  out  6  phase applied to test3
rd_valid  out  1  result available
rd_ready  in  1  readout accepts result
rd_dnn_0  out  48  result word 0
rd_dnn_1  out  48  result word 1
rd_phase  out  6  phase of the result
rd_iter  out  8  repeat index of the result
o_busy  out  1  sweep in progress
o_done  out  1  sweep finished (sticky)
o_timeout_err  out  1  a run timed out (sticky)
o_cfg_err  out  1  cfg_phase_start > cfg_phase_stop (sticky)

Behaviour:
- Reset (reset=1 or enable=0): state IDLE; all outputs 0; FIFO emptied; phase, iter and timeout counters 0.
- Config inputs are sampled into internal registers on accepted sweep_start. They are ignored at all other times.
- States: IDLE, LAUNCH, WAIT_DONE, STORE, ADVANCE, FINISH.
- IDLE:
  - sweep_start clears o_done and all sticky errors.
  - If start > stop: set o_cfg_err and go to FINISH; no run is launched.
  - Otherwise load phase=start, iter=0 and go to LAUNCH.
  - sweep_start while not IDLE is ignored.
- LAUNCH:
  - Stay here while the FIFO is full (count==FIFO_DEPTH).
  - Otherwise drive o_test_start_re=1 for exactly one cycle (registered; high in the cycle after the leaving edge), clear the timeout counter, and go to WAIT_DONE.
  - Launching only with a free slot guarantees the FIFO never overflows.
- WAIT_DONE:
  - Track the rising edge of test3_status_done (registered previous value).
  - A level already high at launch does not count; test3 holds done high in its IDLE until the next run clears it.
  - Rising edge: go to STORE.
  - Counter reaches TIMEOUT_CYCLES-1: set o_timeout_err and go to FINISH.
- STORE: push {dnn_0, dnn_1, phase, iter} into the FIFO for one cycle, then go to ADVANCE.
- ADVANCE:
  - If iter+1 < effective repeat: iter++ and go to LAUNCH.
  - Otherwise iter=0 and compute next = phase + effective step in 7-bit arithmetic.
  - If next > stop or next > 63: go to FINISH. There is no wrap-around.
  - Otherwise phase=next and go to LAUNCH.
- FINISH: set o_done=1 and go to IDLE. o_done holds until the next sweep_start or reset.
- sweep_abort in LAUNCH, WAIT_DONE, STORE or ADVANCE: go to FINISH next cycle.
  - No further push; a STORE in progress that same cycle still completes its push.
  - Entries already in the FIFO stay readable.
- o_busy = 1 in every state except IDLE.
- o_test_trig_out_phase is registered from the phase register. It is stable from LAUNCH through WAIT_DONE.
- FIFO and readout:
  - First-word fall-through; rd_valid = not empty.
  - Pop when rd_valid and rd_ready.
  - Simultaneous push and pop when full is impossible (no push when full). A simultaneous push and pop otherwise leaves the count unchanged.
  - The FIFO is not flushed by sweep_start, only by reset.

Decomposition:
- cms_pix28_package gains:
  - enum state_t_sm_ip2_test3_sweep with states IDLE_IP2_T3S, LAUNCH_IP2_T3S, WAIT_DONE_IP2_T3S, STORE_IP2_T3S, ADVANCE_IP2_T3S, FINISH_IP2_T3S;
  - localparam IP2_T3S_ENTRY_W = 110.
- Sub-module ip2_sweep_fifo: synchronous FIFO, parameters WIDTH and DEPTH, push/pop/full/empty/count, synchronous active-high reset.

Test Plan:
- start=10, stop=12, step=1, repeat=1; test3 model asserts done 50 cycles after each start -> exactly 3 start pulses; rd entries have phases 10, 11, 12 with rd_dnn matching the model data; o_done=1; no errors.
- start=0, stop=63, step=0, repeat=2 with rd_ready held low -> the first 4 runs complete, then stall in LAUNCH with no 5th start pulse. Raising rd_ready resumes the sweep; 128 entries total; the last entry has phase=63, iter=1; no wrap.
- start=60, stop=63, step=5 -> a single run at phase 60; finish because next=65 > 63.
- start=20, stop=5 -> o_cfg_err=1 and o_done=1 within 3 cycles; zero start pulses; FIFO empty.
- Model never raises done, TIMEOUT_CYCLES=64 -> o_timeout_err=1 exactly 64 cycles after the start pulse; o_done=1; nothing pushed.
- Abort during WAIT_DONE of the 2nd run: earlier entry readable, no 2nd entry, o_busy low 2 cycles later. Also check synchronous reset mid-sweep clears everything on the next edge.
